// File: rtl/iob_dbus_split_pkg.sv
// iob_dbus_split_pkg: shared types and constants for the IOb data-bus splitter.
//   state_t   : splitter FSM encoding (IDLE / RD_PEND / ERR_RD)
//   ERR_DATA  : read data returned for unmapped reads (error responder)
//   req_w/resp_w and field-offset helpers for the packed IOb buses.
// Request layout  MSB->LSB {avalid, addr, wdata, wstrb}
// Response layout MSB->LSB {rdata, rvalid, ready}
package iob_dbus_split_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_PEND = 2'd1,
    ST_ERR_RD  = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  // response field positions (independent of widths)
  localparam int RESP_READY_BIT  = 0;
  localparam int RESP_RVALID_BIT = 1;
  localparam int RESP_RDATA_LSB  = 2;

  function automatic int req_w(input int data_w, input int addr_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int resp_w(input int data_w);
    return data_w + 2;
  endfunction

  function automatic int req_wdata_lsb(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int req_addr_lsb(input int data_w);
    return data_w + data_w / 8;
  endfunction

  function automatic int req_avalid_bit(input int data_w, input int addr_w);
    return addr_w + data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/iob_dbus_split_if.sv
// iob_dbus_split_if: bundle of the master-side and slave-side IOb buses.
//   m_req  : master request            (REQ_W)
//   m_resp : master response           (RESP_W)
//   s_req  : slave requests, slave k at [k*REQ_W +: REQ_W]
//   s_resp : slave responses, slave k at [k*RESP_W +: RESP_W]
// Modports:
//   slave  : the splitter's view (it is the CPU's slave)
//   master : the environment's view (CPU + downstream slaves)
interface iob_dbus_split_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int N_SLAVES = 4
);
  import iob_dbus_split_pkg::*;

  localparam int REQ_W  = req_w(DATA_W, ADDR_W);
  localparam int RESP_W = resp_w(DATA_W);

  logic [REQ_W-1:0]           m_req;
  logic [RESP_W-1:0]          m_resp;
  logic [N_SLAVES*REQ_W-1:0]  s_req;
  logic [N_SLAVES*RESP_W-1:0] s_resp;

  modport slave  (input  m_req, s_resp, output m_resp, s_req);
  modport master (output m_req, s_resp, input  m_resp, s_req);

endinterface

// File: rtl/iob_dbus_split_err.sv
// iob_dbus_split_err: internal responder for accesses to unmapped selects.
//   hit    in  : IDLE and the current request selects no slave
//   err_rd in  : FSM is in ERR_RD (the cycle after an unmapped read accept)
//   ready  out : immediate acceptance of the unmapped request
//   rvalid out : read completion during ERR_RD
//   rdata  out : ERR_DATA truncated / zero-extended to DATA_W during ERR_RD
module iob_dbus_split_err
  import iob_dbus_split_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              hit,
  input  logic              err_rd,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  assign ready  = hit;
  assign rvalid = err_rd;
  assign rdata  = err_rd ? DATA_W'(ERR_DATA) : '0;

endmodule

// File: rtl/iob_dbus_split.sv
// iob_dbus_split: routes one IOb master to N_SLAVES slaves by the address
// select field addr[SEL_LSB +: SEL_W], and steers the single outstanding
// read's rvalid/rdata back from the slave that accepted it.
// Ports:
//   clk_i  in  : clock
//   rst_i  in  : synchronous active-high reset
//   cke_i  in  : clock enable; state, rsp_sel and err_o hold when low
//   bus        : iob_dbus_split_if.slave (m_req/m_resp/s_req/s_resp)
//   err_o  out : sticky unmapped-access flag
// Optional feature macro: IOB_DBUS_SPLIT_ERR_EN
//   defined   : selects >= N_SLAVES go to an internal error responder
//               (reads return ERR_DATA via ERR_RD) and set err_o
//   undefined : selects >= N_SLAVES alias to slave N_SLAVES-1, err_o = 0
module iob_dbus_split
  import iob_dbus_split_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int N_SLAVES = 4,
  parameter int SEL_W    = 2,
  parameter int SEL_LSB  = ADDR_W - SEL_W
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           cke_i,
  iob_dbus_split_if.slave bus,
  output logic           err_o
);

  localparam int REQ_W    = req_w(DATA_W, ADDR_W);
  localparam int RESP_W   = resp_w(DATA_W);
  localparam int WSTRB_W  = DATA_W / 8;
  localparam int SEL_BIT0 = req_addr_lsb(DATA_W) + SEL_LSB;
  localparam int AV_BIT   = req_avalid_bit(DATA_W, ADDR_W);

  state_t             state;
  logic [SEL_W-1:0]   rsp_sel;

  logic               avalid, is_read, sel_oob, unmapped, idle, accept;
  logic [SEL_W-1:0]   req_sel, tgt;
  logic               m_ready, m_rvalid;
  logic [DATA_W-1:0]  m_rdata;
  logic               e_ready, e_rvalid;
  logic [DATA_W-1:0]  e_rdata;

  logic [N_SLAVES-1:0]             s_ready, s_rvalid;
  logic [N_SLAVES-1:0][DATA_W-1:0] s_rdata;

  assign avalid  = bus.m_req[AV_BIT];
  assign is_read = (bus.m_req[0 +: WSTRB_W] == '0);
  assign req_sel = bus.m_req[SEL_BIT0 +: SEL_W];
  assign sel_oob = (int'(req_sel) >= N_SLAVES);
  // out-of-range selects alias to the last slave; with the error
  // responder enabled they never reach a slave (unmapped masks them)
  assign tgt     = sel_oob ? SEL_W'(N_SLAVES - 1) : req_sel;
  assign idle    = (state == ST_IDLE);

`ifdef IOB_DBUS_SPLIT_ERR_EN
  assign unmapped = sel_oob;

  iob_dbus_split_err #(.DATA_W(DATA_W)) u_err (
    .hit    (idle & sel_oob),
    .err_rd (state == ST_ERR_RD),
    .ready  (e_ready),
    .rvalid (e_rvalid),
    .rdata  (e_rdata)
  );
`else
  assign unmapped = 1'b0;
  assign e_ready  = 1'b0;
  assign e_rvalid = 1'b0;
  assign e_rdata  = '0;
`endif

  // per-slave unpack of responses and request steering
  for (genvar k = 0; k < N_SLAVES; k++) begin : g_slv
    assign s_ready[k]  = bus.s_resp[k*RESP_W + RESP_READY_BIT];
    assign s_rvalid[k] = bus.s_resp[k*RESP_W + RESP_RVALID_BIT];
    assign s_rdata[k]  = bus.s_resp[k*RESP_W + RESP_RDATA_LSB +: DATA_W];
    assign bus.s_req[k*REQ_W +: REQ_W] =
      (idle && !unmapped && (tgt == SEL_W'(k))) ? bus.m_req : '0;
  end

  // rvalid only comes from the slave recorded at accept time, and only
  // in RD_PEND/ERR_RD, so stray slave rvalids never reach the master
  always_comb begin
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    unique case (state)
      ST_IDLE:    m_ready = unmapped ? e_ready : s_ready[tgt];
      ST_RD_PEND: begin
        m_rvalid = s_rvalid[rsp_sel];
        m_rdata  = s_rdata[rsp_sel];
      end
      ST_ERR_RD:  begin
        m_rvalid = e_rvalid;
        m_rdata  = e_rdata;
      end
      default: ;
    endcase
  end

  assign bus.m_resp = {m_rdata, m_rvalid, m_ready};
  assign accept     = avalid & m_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      rsp_sel <= '0;
    end else if (cke_i) begin
      unique case (state)
        ST_IDLE: begin
          if (accept && is_read) begin
            if (unmapped) begin
              state <= ST_ERR_RD;
            end else begin
              rsp_sel <= tgt;
              state   <= ST_RD_PEND;
            end
          end
        end
        ST_RD_PEND: if (s_rvalid[rsp_sel]) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

`ifdef IOB_DBUS_SPLIT_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                             err_q <= 1'b0;
    else if (cke_i && accept && unmapped)  err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_iob_dbus_split.sv
// tb_iob_dbus_split: directed self-checking bench for iob_dbus_split.
// dut  : N_SLAVES=4, SEL_W=2 (routing, stall, stray rvalid, reset, cke)
// dut3 : N_SLAVES=3, SEL_W=2 (unmapped select 3: alias or error responder)
module tb_iob_dbus_split;
  import iob_dbus_split_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int REQ_W  = 69;
  localparam int RESP_W = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cke = 1'b1;
  logic err4, err3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iob_dbus_split_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_SLAVES(4)) bus4();
  iob_dbus_split_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_SLAVES(3)) bus3();

  iob_dbus_split #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_SLAVES(4), .SEL_W(2), .SEL_LSB(30)) dut (
    .clk_i(clk), .rst_i(rst), .cke_i(cke), .bus(bus4), .err_o(err4));

  iob_dbus_split #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_SLAVES(3), .SEL_W(2), .SEL_LSB(30)) dut3 (
    .clk_i(clk), .rst_i(rst), .cke_i(cke), .bus(bus3), .err_o(err3));

  function automatic logic [REQ_W-1:0] mk_req(input logic av, input logic [31:0] a,
                                              input logic [31:0] d, input logic [3:0] s);
    return {av, a, d, s};
  endfunction

  function automatic logic [RESP_W-1:0] mk_rsp(input logic [31:0] d, input logic rv, input logic rdy);
    return {d, rv, rdy};
  endfunction

  function automatic logic [REQ_W-1:0] sreq4(input int k);
    return bus4.s_req[k*REQ_W +: REQ_W];
  endfunction

  task automatic set4(input int k, input logic [RESP_W-1:0] r);
    bus4.s_resp[k*RESP_W +: RESP_W] = r;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cke = 1'b1;
    bus4.m_req = '0; bus4.s_resp = '0;
    bus3.m_req = '0; bus3.s_resp = '0;
    step(); step();
    rst = 1'b0; #1;
    checks++; if (bus4.m_resp !== '0) begin errors++; $display("FAIL rst_m_resp: got %h exp 0", bus4.m_resp); end
    checks++; if (bus4.s_req !== '0) begin errors++; $display("FAIL rst_s_req: got %h exp 0", bus4.s_req); end
    checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL rst_err4: got %b exp 0", err4); end
    checks++; if (bus3.m_resp !== '0) begin errors++; $display("FAIL rst_m_resp3: got %h exp 0", bus3.m_resp); end
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL rst_err3: got %b exp 0", err3); end
  endtask

  task automatic test_write_read();
    logic [REQ_W-1:0] r;
    r = mk_req(1'b1, 32'h4000_0010, 32'h1234_5678, 4'hF);
    bus4.m_req = r; #1;
    checks++; if (sreq4(1) !== r) begin errors++; $display("FAIL wr_sreq1: got %h exp %h", sreq4(1), r); end
    for (int k = 0; k < 4; k++) begin
      if (k != 1) begin
        checks++; if (sreq4(k) !== '0) begin errors++; $display("FAIL wr_sreq_other%0d: got %h exp 0", k, sreq4(k)); end
      end
    end
    checks++; if (bus4.m_resp[0] !== 1'b0) begin errors++; $display("FAIL wr_ready_low: got %b exp 0", bus4.m_resp[0]); end
    set4(1, mk_rsp(32'h0, 1'b0, 1'b1)); #1;
    checks++; if (bus4.m_resp[0] !== 1'b1) begin errors++; $display("FAIL wr_ready_high: got %b exp 1", bus4.m_resp[0]); end
    step();
    // still IDLE after write: a read to the same slave is accepted at once
    r = mk_req(1'b1, 32'h4000_0010, 32'h0, 4'h0);
    bus4.m_req = r; #1;
    checks++; if (bus4.m_resp[0] !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b exp 1", bus4.m_resp[0]); end
    checks++; if (sreq4(1) !== r) begin errors++; $display("FAIL rd_sreq1: got %h exp %h", sreq4(1), r); end
    step();
    bus4.m_req = '0; set4(1, '0); #1;
    checks++; if (bus4.m_resp !== '0) begin errors++; $display("FAIL rd_wait: got %h exp 0", bus4.m_resp); end
    step();
    set4(1, mk_rsp(32'h1234_5678, 1'b1, 1'b0)); #1;
    checks++; if (bus4.m_resp !== mk_rsp(32'h1234_5678, 1'b1, 1'b0)) begin
      errors++; $display("FAIL rd_data: got %h exp %h", bus4.m_resp, mk_rsp(32'h1234_5678, 1'b1, 1'b0)); end
    step();
    set4(1, '0); #1;
    checks++; if (bus4.m_resp !== '0) begin errors++; $display("FAIL rd_back_idle: got %h exp 0", bus4.m_resp); end
  endtask

  task automatic test_stall();
    logic [REQ_W-1:0] r, w;
    r = mk_req(1'b1, 32'hC000_0000, 32'h0, 4'h0);
    bus4.m_req = r; set4(3, mk_rsp(32'h0, 1'b0, 1'b1)); #1;
    checks++; if (bus4.m_resp[0] !== 1'b1) begin errors++; $display("FAIL st_accept: got %b exp 1", bus4.m_resp[0]); end
    step();
    w = mk_req(1'b1, 32'h0000_0004, 32'h0000_CAFE, 4'h3);
    set4(3, '0); bus4.m_req = w; set4(0, mk_rsp(32'h0, 1'b0, 1'b1));
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (sreq4(0) !== '0) begin errors++; $display("FAIL st_sreq0_c%0d: got %h exp 0", i, sreq4(0)); end
      checks++; if (bus4.m_resp[0] !== 1'b0) begin errors++; $display("FAIL st_ready_c%0d: got %b exp 0", i, bus4.m_resp[0]); end
      step();
    end
    set4(3, mk_rsp(32'hA5A5_0003, 1'b1, 1'b0)); #1;
    checks++; if (bus4.m_resp !== mk_rsp(32'hA5A5_0003, 1'b1, 1'b0)) begin
      errors++; $display("FAIL st_rdata: got %h exp %h", bus4.m_resp, mk_rsp(32'hA5A5_0003, 1'b1, 1'b0)); end
    checks++; if (sreq4(0) !== '0) begin errors++; $display("FAIL st_sreq0_rv: got %h exp 0", sreq4(0)); end
    step();
    set4(3, '0); #1;
    checks++; if (bus4.m_resp[0] !== 1'b1) begin errors++; $display("FAIL st_release_ready: got %b exp 1", bus4.m_resp[0]); end
    checks++; if (sreq4(0) !== w) begin errors++; $display("FAIL st_release_sreq0: got %h exp %h", sreq4(0), w); end
    step();
    bus4.m_req = '0; set4(0, '0);
  endtask

  task automatic test_stray();
    set4(2, mk_rsp(32'hFFFF_FFFF, 1'b1, 1'b0)); #1;
    checks++; if (bus4.m_resp !== '0) begin errors++; $display("FAIL stray_idle: got %h exp 0", bus4.m_resp); end
    bus4.m_req = mk_req(1'b1, 32'h4000_0000, 32'h0, 4'h0); set4(1, mk_rsp(32'h0, 1'b0, 1'b1)); #1;
    checks++; if (bus4.m_resp !== mk_rsp(32'h0, 1'b0, 1'b1)) begin
      errors++; $display("FAIL stray_accept: got %h exp %h", bus4.m_resp, mk_rsp(32'h0, 1'b0, 1'b1)); end
    step();
    bus4.m_req = '0; set4(1, '0); #1;
    checks++; if (bus4.m_resp[1] !== 1'b0) begin errors++; $display("FAIL stray_pend: got %b exp 0", bus4.m_resp[1]); end
    step();
    set4(1, mk_rsp(32'h0000_0011, 1'b1, 1'b0)); #1;
    checks++; if (bus4.m_resp !== mk_rsp(32'h0000_0011, 1'b1, 1'b0)) begin
      errors++; $display("FAIL stray_own: got %h exp %h", bus4.m_resp, mk_rsp(32'h0000_0011, 1'b1, 1'b0)); end
    step();
    set4(1, '0); set4(2, '0);
  endtask

  task automatic test_reset_mid_read();
    logic [REQ_W-1:0] r;
    r = mk_req(1'b1, 32'h0000_0100, 32'h0, 4'h0);
    bus4.m_req = r; set4(0, mk_rsp(32'h0, 1'b0, 1'b1)); #1;
    checks++; if (bus4.m_resp[0] !== 1'b1) begin errors++; $display("FAIL rm_accept: got %b exp 1", bus4.m_resp[0]); end
    step();
    bus4.m_req = '0; set4(0, '0);
    rst = 1'b1; step(); rst = 1'b0;
    set4(0, mk_rsp(32'hBAD0_BAD0, 1'b1, 1'b0)); #1;
    checks++; if (bus4.m_resp !== '0) begin errors++; $display("FAIL rm_dropped: got %h exp 0", bus4.m_resp); end
    step();
    bus4.m_req = r; set4(0, mk_rsp(32'h0, 1'b0, 1'b1)); #1;
    checks++; if (bus4.m_resp[0] !== 1'b1) begin errors++; $display("FAIL rm_new_accept: got %b exp 1", bus4.m_resp[0]); end
    step();
    bus4.m_req = '0; set4(0, '0); step();
    set4(0, mk_rsp(32'h600D_F00D, 1'b1, 1'b0)); #1;
    checks++; if (bus4.m_resp !== mk_rsp(32'h600D_F00D, 1'b1, 1'b0)) begin
      errors++; $display("FAIL rm_new_data: got %h exp %h", bus4.m_resp, mk_rsp(32'h600D_F00D, 1'b1, 1'b0)); end
    step();
    set4(0, '0);
  endtask

  task automatic test_cke();
    logic [REQ_W-1:0] w;
    bus4.m_req = mk_req(1'b1, 32'h8000_0000, 32'h0, 4'h0); set4(2, mk_rsp(32'h0, 1'b0, 1'b1)); #1;
    checks++; if (bus4.m_resp[0] !== 1'b1) begin errors++; $display("FAIL cke_accept: got %b exp 1", bus4.m_resp[0]); end
    step();
    cke = 1'b0;
    set4(2, mk_rsp(32'h2222_2222, 1'b1, 1'b0));
    w = mk_req(1'b1, 32'h0000_0020, 32'h0000_5555, 4'h1);
    bus4.m_req = w; set4(0, mk_rsp(32'h0, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus4.m_resp !== mk_rsp(32'h2222_2222, 1'b1, 1'b0)) begin
        errors++; $display("FAIL cke_hold_c%0d: got %h exp %h", i, bus4.m_resp, mk_rsp(32'h2222_2222, 1'b1, 1'b0)); end
      checks++; if (sreq4(0) !== '0) begin errors++; $display("FAIL cke_sreq0_c%0d: got %h exp 0", i, sreq4(0)); end
      step();
    end
    cke = 1'b1; #1;
    checks++; if (bus4.m_resp !== mk_rsp(32'h2222_2222, 1'b1, 1'b0)) begin
      errors++; $display("FAIL cke_still_pend: got %h exp %h", bus4.m_resp, mk_rsp(32'h2222_2222, 1'b1, 1'b0)); end
    step();
    set4(2, '0); #1;
    checks++; if (bus4.m_resp !== mk_rsp(32'h0, 1'b0, 1'b1)) begin
      errors++; $display("FAIL cke_idle: got %h exp %h", bus4.m_resp, mk_rsp(32'h0, 1'b0, 1'b1)); end
    checks++; if (sreq4(0) !== w) begin errors++; $display("FAIL cke_sreq0_fwd: got %h exp %h", sreq4(0), w); end
    step();
    bus4.m_req = '0; set4(0, '0);
  endtask

  task automatic test_unmapped_n3();
    logic [REQ_W-1:0] r;
    r = mk_req(1'b1, 32'hC000_0000, 32'h0, 4'h0);
    bus3.s_resp = '0; bus3.m_req = r;
`ifdef IOB_DBUS_SPLIT_ERR_EN
    #1;
    checks++; if (bus3.m_resp !== mk_rsp(32'h0, 1'b0, 1'b1)) begin
      errors++; $display("FAIL n3_err_ready: got %h exp %h", bus3.m_resp, mk_rsp(32'h0, 1'b0, 1'b1)); end
    checks++; if (bus3.s_req !== '0) begin errors++; $display("FAIL n3_err_sreq: got %h exp 0", bus3.s_req); end
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL n3_err_pre: got %b exp 0", err3); end
    step();
    bus3.m_req = '0; #1;
    checks++; if (bus3.m_resp !== mk_rsp(32'hDEAD_BEEF, 1'b1, 1'b0)) begin
      errors++; $display("FAIL n3_err_rdata: got %h exp %h", bus3.m_resp, mk_rsp(32'hDEAD_BEEF, 1'b1, 1'b0)); end
    checks++; if (err3 !== 1'b1) begin errors++; $display("FAIL n3_err_set: got %b exp 1", err3); end
    step();
    checks++; if (bus3.m_resp !== '0) begin errors++; $display("FAIL n3_err_idle: got %h exp 0", bus3.m_resp); end
    bus3.m_req = mk_req(1'b1, 32'h0000_0008, 32'h0000_0077, 4'hF);
    bus3.s_resp[0 +: RESP_W] = mk_rsp(32'h0, 1'b0, 1'b1); #1;
    checks++; if (bus3.m_resp[0] !== 1'b1) begin errors++; $display("FAIL n3_good_ready: got %b exp 1", bus3.m_resp[0]); end
    step();
    bus3.m_req = '0; bus3.s_resp = '0; #1;
    checks++; if (err3 !== 1'b1) begin errors++; $display("FAIL n3_err_sticky: got %b exp 1", err3); end
`else
    bus3.s_resp[2*RESP_W +: RESP_W] = mk_rsp(32'h0, 1'b0, 1'b1); #1;
    checks++; if (bus3.s_req[2*REQ_W +: REQ_W] !== r) begin
      errors++; $display("FAIL n3_alias_sreq2: got %h exp %h", bus3.s_req[2*REQ_W +: REQ_W], r); end
    checks++; if (bus3.m_resp !== mk_rsp(32'h0, 1'b0, 1'b1)) begin
      errors++; $display("FAIL n3_alias_ready: got %h exp %h", bus3.m_resp, mk_rsp(32'h0, 1'b0, 1'b1)); end
    step();
    bus3.m_req = '0; bus3.s_resp = '0; step();
    bus3.s_resp[2*RESP_W +: RESP_W] = mk_rsp(32'h3333_3333, 1'b1, 1'b0); #1;
    checks++; if (bus3.m_resp !== mk_rsp(32'h3333_3333, 1'b1, 1'b0)) begin
      errors++; $display("FAIL n3_alias_rdata: got %h exp %h", bus3.m_resp, mk_rsp(32'h3333_3333, 1'b1, 1'b0)); end
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL n3_alias_err: got %b exp 0", err3); end
    step();
    bus3.s_resp = '0;
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_stall();
    test_stray();
    test_reset_mid_read();
    test_cke();
    test_unmapped_n3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/iob_dbus_split.md
Name: iob_dbus_split

Overview:
- Routes the CPU data bus (IOb native request/response, one master) to N_SLAVES peripheral/memory slaves.
- Selection uses the upper address bits.
- Tracks the single outstanding read so its rvalid/rdata return from the slave that accepted it.
- Sits directly downstream of the RISC-V core wrapper's dbus_req/dbus_resp and upstream of SRAM, external-memory and peripheral ports.

Parameters:
- DATA_W, 32: data width.
- ADDR_W, 32: request address width.
- N_SLAVES, 4: number of slave ports, 2..16.
- SEL_W, 2: select field width, 2**SEL_W >= N_SLAVES.
- SEL_LSB, ADDR_W-SEL_W: lowest bit of the select field.
- Derived REQ_W = 1+ADDR_W+DATA_W+DATA_W/8; layout MSB->LSB {avalid, addr, wdata, wstrb}.
- Derived RESP_W = DATA_W+2; layout MSB->LSB {rdata, rvalid, ready}.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cke_i  in  1  clock enable; state holds when low.
- m_req  in  REQ_W  master request.
- m_resp  out  RESP_W  master response.
- s_req  out  N_SLAVES*REQ_W  slave requests; slave k occupies bits [k*REQ_W +: REQ_W].
- s_resp  in  N_SLAVES*RESP_W  slave responses, same packing.
- err_o  out  1  sticky unmapped-access flag; constant 0 unless IOB_DBUS_SPLIT_ERR_EN.

Behaviour:
- req_sel = m_req.addr[SEL_LSB +: SEL_W].
- States:
  - IDLE: accepts requests.
  - RD_PEND: read accepted, waiting for its rvalid.
- Register rsp_sel[SEL_W] records the slave owing the read data.
- Reset: state=IDLE, rsp_sel=0, err_o=0.
- m_resp and s_req are combinational from state, rsp_sel and the inputs. With m_req.avalid=0 after reset, all outputs are 0.
- IDLE request forwarding:
  - s_req[req_sel] = m_req.
  - Every other slave gets all-zero requests (avalid=0, wstrb=0).
  - m_resp.ready = s_resp[req_sel].ready.
- Accept = m_req.avalid & m_resp.ready, both in the same cycle.
- Read accepted (wstrb==0): rsp_sel<=req_sel, IDLE->RD_PEND on the next edge.
- Write accepted (wstrb!=0): stays in IDLE. Write completion is ready alone; no rvalid is expected or forwarded.
- RD_PEND:
  - All s_req avalid=0 and m_resp.ready=0; master requests are stalled.
  - m_resp.rdata/rvalid = s_resp[rsp_sel].rdata/rvalid.
  - On rvalid=1: RD_PEND->IDLE. The next request is accepted no earlier than the following cycle (min read-to-read spacing 2 cycles + slave latency).
- In IDLE, m_resp.rvalid=0 and rdata=0. Stray slave rvalids are ignored.
- Slave answering ready and rvalid in the same cycle as a read accept: rvalid is not forwarded in that cycle. Slaves must return rvalid at least one cycle after ready.
- Reset mid-read forces IDLE; the pending rvalid is dropped.
- cke_i=0 freezes state, rsp_sel and err_o. Combinational routing continues.
- Select >= N_SLAVES with the macro undefined: aliases to slave N_SLAVES-1.

Optional Feature:
- Macro: IOB_DBUS_SPLIT_ERR_EN.
- Defined — a request with req_sel >= N_SLAVES is handled by an internal error responder:
  - ready=1 in the same cycle; no slave sees avalid.
  - Read: state ERR_RD for one cycle, m_resp.rvalid=1, rdata=32'hDEAD_BEEF (truncated/zero-extended to DATA_W), then IDLE.
  - Write: dropped.
  - Either case sets err_o=1; it stays 1 until rst_i.
- Undefined: aliasing as above, err_o tied 0, no ERR_RD state.

Decomposition:
- Shared header iob_dbus_split.vh:
  - REQ_W/RESP_W formulas.
  - Field offset macros (avalid, address, wdata, wstrb, rdata, rvalid, ready).
  - State encodings: IDLE=2'd0, RD_PEND=2'd1, ERR_RD=2'd2.
  - ERR_DATA constant.
- One sub-module, iob_dbus_split_err: the error responder (ready/rvalid/rdata generation), instantiated only under the macro.
- State and rsp_sel registers use the standard iob_reg with cke.

Test Plan:
- Write then read, N_SLAVES=4, SEL_W=2:
  - Write addr 0x4000_0010, wstrb=4'hF, wdata=0x1234_5678: only s_req[1].avalid=1; m_resp.ready follows s_resp[1].ready; no state change.
  - Read of same address, slave 1 rvalid 2 cycles after ready with rdata=0x1234_5678: m_resp returns it; state returns to IDLE.
- Read to slave 3 (addr 0xC000_0000) held in RD_PEND 5 cycles; master presents a write to slave 0 meanwhile: s_req[0].avalid stays 0 and m_resp.ready=0 until the cycle after slave 3 rvalid.
- Stray s_resp[2].rvalid=1 while in IDLE, then while RD_PEND to slave 1: m_resp.rvalid stays 0 both times.
- rst_i pulsed while RD_PEND: next cycle state=IDLE; later slave rvalid ignored; a new read to slave 0 completes normally.
- N_SLAVES=3, macro on: read addr 0xC000_0000 -> ready same cycle, rvalid next cycle with 0xDEAD_BEEF, err_o=1 and remains 1 after further good accesses.
- N_SLAVES=3, macro off: the same read reaches slave 2; err_o=0.
- cke_i=0 for 3 cycles during RD_PEND: slave 2 rvalid is still forwarded combinationally; state leaves RD_PEND only on the first cke_i=1 edge.
